cnn_cmd_issuer: RTL

// - Host-side initiator for ctrl_cnn: accepts one 14-bit command, drives op_code to the CNN controller,

---
 rtl/cnn_cmd_issuer.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/cnn_cmd_issuer.sv
// cnn_cmd_issuer: single-job command and weight issuer in front of ctrl_cnn.
// Define CMD_TIMEOUT_EN to add a TMO_CYC-cycle watchdog on LOAD and WAIT.
module cnn_cmd_issuer #(
  parameter int unsigned NUM_FILT = 32,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned TMO_CYC  = 4096
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [13:0]         cmd_op_i,
  input  logic                wt_valid_i,
  output logic                wt_ready_o,
  input  logic [DATA_W-1:0]   wt_data_i,
  output logic [13:0]         op_code_o,
  output logic [DATA_W-1:0]   wt_data_o,
  output logic [NUM_FILT-1:0] wt_we_o,
  input  logic                ctrl_done_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_LOAD,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_e;

  localparam logic [NUM_FILT-1:0] WE_ONE =
    {{(NUM_FILT-1){1'b0}}, 1'b1};

  state_e              state_q;
  logic [13:0]         op_q;
  logic [4:0]          elem_q;
  logic [5:0]          filt_q;
  logic                cmd_rdy_q;
  logic                wt_rdy_q;
  logic [13:0]         op_code_q;
  logic [DATA_W-1:0]   wt_data_q;
  logic [NUM_FILT-1:0] wt_we_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  logic [2:0] op_f;
  logic [5:0] nf_f;
  logic [4:0] wd_f;
  logic       wt_op;
  logic       bad_cmd;
  logic       xfer;
  logic       elem_last;
  logic       filt_last;
  logic       tmo_hit;

  assign op_f = op_q[2:0];
  assign nf_f = op_q[8:3];
  assign wd_f = op_q[13:9];

  assign wt_op = (op_f == 3'b001) ||
                 (op_f == 3'b010) ||
                 (op_f == 3'b110);

  assign bad_cmd = (op_f == 3'b000) ||
                   (wt_op && ((nf_f == 6'd0) ||
                              (32'(nf_f) > NUM_FILT) ||
                              (wd_f == 5'd0)));

  assign xfer      = wt_rdy_q & wt_valid_i;
  assign elem_last = (elem_q == wd_f - 5'd1);
  assign filt_last = (filt_q == nf_f - 6'd1);

`ifdef CMD_TIMEOUT_EN
  localparam logic [15:0] TMO_LIM = 16'(TMO_CYC - 1);

  logic [15:0] wdog_q;
  logic        wdog_act;

  assign wdog_act = (state_q == S_LOAD) || (state_q == S_WAIT);
  assign tmo_hit  = wdog_act && !xfer && (wdog_q == TMO_LIM);

  // Restarts on every accepted word and on entry to LOAD/WAIT.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wdog_q <= '0;
    end else if (wdog_act && !xfer && !tmo_hit) begin
      wdog_q <= wdog_q + 16'd1;
    end else begin
      wdog_q <= '0;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TMO_CYC;
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      elem_q    <= '0;
      filt_q    <= '0;
      cmd_rdy_q <= 1'b1;
      wt_rdy_q  <= 1'b0;
      op_code_q <= '0;
      wt_data_q <= '0;
      wt_we_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      wt_we_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            op_q      <= cmd_op_i;
            cmd_rdy_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_CHECK;
          end
        end
        S_CHECK: begin
          elem_q <= '0;
          filt_q <= '0;
          if (bad_cmd) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_ERR;
          end else begin
            op_code_q <= op_q;
            if (wt_op) begin
              wt_rdy_q <= 1'b1;
              state_q  <= S_LOAD;
            end else begin
              state_q <= S_WAIT;
            end
          end
        end
        S_LOAD: begin
          if (tmo_hit) begin
            err_q     <= 1'b1;
            busy_q    <= 1'b0;
            wt_rdy_q  <= 1'b0;
            op_code_q <= '0;
            state_q   <= S_ERR;
          end else if (xfer) begin
            wt_data_q <= wt_data_i;
            wt_we_q   <= WE_ONE << filt_q;
            if (elem_last) begin
              elem_q <= '0;
              filt_q <= filt_q + 6'd1;
              if (filt_last) begin
                wt_rdy_q <= 1'b0;
                state_q  <= S_WAIT;
              end
            end else begin
              elem_q <= elem_q + 5'd1;
            end
          end
        end
        S_WAIT: begin
          if (tmo_hit) begin
            err_q     <= 1'b1;
            busy_q    <= 1'b0;
            op_code_q <= '0;
            state_q   <= S_ERR;
          end else if (ctrl_done_i) begin
            done_q    <= 1'b1;
            op_code_q <= '0;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          elem_q    <= '0;
          filt_q    <= '0;
          busy_q    <= 1'b0;
          cmd_rdy_q <= 1'b1;
          state_q   <= S_IDLE;
        end
        S_ERR: begin
          elem_q    <= '0;
          filt_q    <= '0;
          cmd_rdy_q <= 1'b1;
          state_q   <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o = cmd_rdy_q;
  assign wt_ready_o  = wt_rdy_q;
  assign op_code_o   = op_code_q;
  assign wt_data_o   = wt_data_q;
  assign wt_we_o     = wt_we_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
